// File: rtl/cmd_sequencer_gen2_if.sv
// rtl/cmd_sequencer_gen2_if.sv - command word input, rasterizer handshake and status bundle
interface cmd_sequencer_gen2_if #(
  parameter int COORD_W = 3,
  parameter int PARAM_W = 5,
  parameter int CNT_W   = 8
);
  logic               en;
  logic [1:0]         cmd;
  logic [PARAM_W-1:0] param;
  logic               exec_valid;
  logic               exec_ready;
  logic [1:0]         exec_cmd;
  logic               exec_clear;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic [COORD_W-1:0] x2;
  logic [COORD_W-1:0] y2;
  logic [COORD_W-1:0] width;
  logic [COORD_W-1:0] height;
  logic               busy;
  logic               err_valid;
  logic [1:0]         err_code;
  logic [CNT_W-1:0]   cmd_count;

  modport master (
    output en, cmd, param, exec_ready,
    input  exec_valid, exec_cmd, exec_clear, x1, y1, x2, y2, width, height,
    input  busy, err_valid, err_code, cmd_count
  );

  modport slave (
    input  en, cmd, param, exec_ready,
    output exec_valid, exec_cmd, exec_clear, x1, y1, x2, y2, width, height,
    output busy, err_valid, err_code, cmd_count
  );
endinterface

// File: rtl/cmd_sequencer_gen2.sv
// rtl/cmd_sequencer_gen2.sv - decodes {en, cmd, param} words into draw commands for the rasterizer
module cmd_sequencer_gen2 #(
  parameter int COORD_W = 3,
  parameter int PARAM_W = 5,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  cmd_sequencer_gen2_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  localparam int TO_W = $clog2(TIMEOUT + 2);
  localparam logic [COORD_W-1:0] ALL_ONES = '1;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d, need_q, need_d, cur_cmd_q, cur_cmd_d;
  logic [1:0]         exec_cmd_q, exec_cmd_d, err_code_q, err_code_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               exec_valid_q, exec_valid_d, exec_clear_q, exec_clear_d;
  logic               busy_q, busy_d, err_valid_q, err_valid_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [COORD_W-1:0] width_q, width_d, height_q, height_d;
  logic [CNT_W-1:0]   cmd_count_q, cmd_count_d;
  logic               start, handshake;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    need_d       = need_q;
    cur_cmd_d    = cur_cmd_q;
    exec_cmd_d   = exec_cmd_q;
    to_d         = to_q;
    exec_valid_d = exec_valid_q;
    exec_clear_d = exec_clear_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    x2_d         = x2_q;
    y2_d         = y2_q;
    width_d      = width_q;
    height_d     = height_q;
    cmd_count_d  = cmd_count_q;
    err_valid_d  = 1'b0;
    err_code_d   = 2'b00;
    start        = 1'b0;
    handshake    = exec_valid_q && bus.exec_ready;

    unique case (state_q)
      IDLE: start = bus.en && (bus.cmd != 2'b00);
      LOAD: begin
        if (bus.en && bus.cmd == 2'b00) begin
          // idx 1 is always y1; slots 2/3 depend on LINE vs RECT
          unique case (idx_q)
            2'd1:    y1_d = bus.param[COORD_W-1:0];
            2'd2:    if (cur_cmd_q == 2'b10) x2_d = bus.param[COORD_W-1:0];
                     else width_d = bus.param[COORD_W-1:0];
            default: if (cur_cmd_q == 2'b10) y2_d = bus.param[COORD_W-1:0];
                     else height_d = bus.param[COORD_W-1:0];
          endcase
          idx_d = idx_q + 2'd1;
          to_d  = '0;
          if (idx_q == need_q) begin
            state_d    = ISSUE;
            exec_cmd_d = cur_cmd_q;
          end
        end else if (bus.en) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b01;
          start       = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
          if (TIMEOUT != 0 && to_d == TO_W'(TIMEOUT)) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b10;
            state_d     = IDLE;
            to_d        = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.en) begin
          err_valid_d = 1'b1;
          err_code_d  = 2'b11;
        end
        // first ISSUE cycle arms exec_valid, which is why issue latency is two edges
        exec_valid_d = 1'b1;
        if (handshake) begin
          state_d      = IDLE;
          exec_valid_d = 1'b0;
          exec_cmd_d   = 2'b00;
          cmd_count_d  = cmd_count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      exec_clear_d = 1'b0;
      idx_d        = 2'd1;
      to_d         = '0;
      cur_cmd_d    = bus.cmd;
      if (bus.cmd == 2'b01 && (&bus.param)) begin
        x1_d         = ALL_ONES;
        y1_d         = ALL_ONES;
        exec_clear_d = 1'b1;
        exec_cmd_d   = 2'b01;
        state_d      = ISSUE;
      end else begin
        x1_d    = bus.param[COORD_W-1:0];
        need_d  = (bus.cmd == 2'b01) ? 2'd1 : 2'd3;
        state_d = LOAD;
      end
    end

    busy_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      need_q       <= '0;
      cur_cmd_q    <= '0;
      exec_cmd_q   <= '0;
      to_q         <= '0;
      exec_valid_q <= 1'b0;
      exec_clear_q <= 1'b0;
      busy_q       <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      width_q      <= '0;
      height_q     <= '0;
      cmd_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      need_q       <= need_d;
      cur_cmd_q    <= cur_cmd_d;
      exec_cmd_q   <= exec_cmd_d;
      to_q         <= to_d;
      exec_valid_q <= exec_valid_d;
      exec_clear_q <= exec_clear_d;
      busy_q       <= busy_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      width_q      <= width_d;
      height_q     <= height_d;
      cmd_count_q  <= cmd_count_d;
    end
  end

  assign bus.exec_valid = exec_valid_q;
  assign bus.exec_cmd   = exec_cmd_q;
  assign bus.exec_clear = exec_clear_q;
  assign bus.x1         = x1_q;
  assign bus.y1         = y1_q;
  assign bus.x2         = x2_q;
  assign bus.y2         = y2_q;
  assign bus.width      = width_q;
  assign bus.height     = height_q;
  assign bus.busy       = busy_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
  assign bus.cmd_count  = cmd_count_q;
endmodule

// File: tb/tb_cmd_sequencer_gen2.sv
// tb/tb_cmd_sequencer_gen2.sv - directed and random checks of cmd_sequencer_gen2 against a word-level model
module tb_cmd_sequencer_gen2;
  localparam int COORD_W = 3;
  localparam int PARAM_W = 5;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;
  localparam int CMASK   = (1 << COORD_W) - 1;
  localparam int PMASK   = (1 << PARAM_W) - 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_ARM = 2, M_PRES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_sequencer_gen2_if #(.COORD_W(COORD_W), .PARAM_W(PARAM_W), .CNT_W(CNT_W)) bus ();

  cmd_sequencer_gen2 #(.COORD_W(COORD_W), .PARAM_W(PARAM_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: registers indexed x1,y1,x2,y2,width,height; argument k of a command lands in a slot table
  int m_mode, m_cmd, m_clear, m_count, m_idle, m_got, m_need, m_err;
  int m_reg[6];
  int line_slot[3] = '{1, 2, 3};
  int rect_slot[3] = '{1, 4, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_start(input int c, input int p);
    if (c == 1 && p == PMASK) begin
      m_reg[0] = CMASK;
      m_reg[1] = CMASK;
      m_clear  = 1;
      m_cmd    = 1;
      m_mode   = M_ARM;
    end else begin
      m_reg[0] = p & CMASK;
      m_clear  = 0;
      m_cmd    = c;
      m_need   = (c == 1) ? 1 : 3;
      m_got    = 0;
      m_idle   = 0;
      m_mode   = M_LOAD;
    end
  endtask

  task automatic model_step(input bit e, input int c, input int p, input bit r);
    int slot;
    m_err = 0;
    if (rst) begin
      m_mode = M_IDLE; m_cmd = 0; m_clear = 0; m_count = 0; m_idle = 0; m_got = 0; m_need = 0;
      for (int i = 0; i < 6; i++) m_reg[i] = 0;
      return;
    end
    case (m_mode)
      M_PRES: begin
        if (e) m_err = 3;
        if (r) begin
          m_count = (m_count + 1) % (1 << CNT_W);
          m_mode  = M_IDLE;
        end
      end
      M_ARM: begin
        if (e) m_err = 3;
        m_mode = M_PRES;
      end
      M_LOAD: begin
        if (e && c == 0) begin
          slot = (m_cmd == 1) ? 1 : (m_cmd == 2) ? line_slot[m_got] : rect_slot[m_got];
          m_reg[slot] = p & CMASK;
          m_got++;
          m_idle = 0;
          if (m_got == m_need) m_mode = M_ARM;
        end else if (e) begin
          m_err = 1;
          model_start(c, p);
        end else begin
          m_idle++;
          if (TIMEOUT > 0 && m_idle == TIMEOUT) begin
            m_err  = 2;
            m_mode = M_IDLE;
          end
        end
      end
      default: if (e && c != 0) model_start(c, p);
    endcase
  endtask

  task automatic check_all();
    bit issuing;
    issuing = (m_mode == M_ARM || m_mode == M_PRES);
    chk("exec_valid", 32'(bus.exec_valid), 32'(m_mode == M_PRES));
    chk("busy",       32'(bus.busy),       32'(issuing));
    chk("exec_cmd",   32'(bus.exec_cmd),   issuing ? 32'(m_cmd) : 32'd0);
    chk("exec_clear", 32'(bus.exec_clear), 32'(m_clear));
    chk("x1",         32'(bus.x1),         32'(m_reg[0]));
    chk("y1",         32'(bus.y1),         32'(m_reg[1]));
    chk("x2",         32'(bus.x2),         32'(m_reg[2]));
    chk("y2",         32'(bus.y2),         32'(m_reg[3]));
    chk("width",      32'(bus.width),      32'(m_reg[4]));
    chk("height",     32'(bus.height),     32'(m_reg[5]));
    chk("err_valid",  32'(bus.err_valid),  32'(m_err != 0));
    chk("err_code",   32'(bus.err_code),   32'(m_err));
    chk("cmd_count",  32'(bus.cmd_count),  32'(m_count));
  endtask

  task automatic cyc(input bit e, input int c, input int p, input bit r);
    bus.en         = e;
    bus.cmd        = 2'(c);
    bus.param      = PARAM_W'(p);
    bus.exec_ready = r;
    @(posedge clk);
    model_step(e, c, p, r);
    #1;
    check_all();
  endtask

  initial begin
    int en_pct;
    bit e, r;
    int c, p;
    bus.en = 1'b0; bus.cmd = 2'b00; bus.param = '0; bus.exec_ready = 1'b0;

    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("reset_count", 32'(bus.cmd_count), 32'd0);
    cyc(1, 0, 9, 0);

    // PIXEL (3,5) with ready held high
    cyc(1, 1, 3, 1);
    cyc(1, 0, 5, 1);
    cyc(0, 0, 0, 1);
    chk("pixel_valid", 32'(bus.exec_valid), 32'd1);
    chk("pixel_x1", 32'(bus.x1), 32'd3);
    chk("pixel_y1", 32'(bus.y1), 32'd5);
    cyc(0, 0, 0, 1);
    chk("pixel_count", 32'(bus.cmd_count), 32'd1);
    chk("pixel_cmd_idle", 32'(bus.exec_cmd), 32'd0);

    // RECT with a stalled rasterizer and an overrun word during the stall
    cyc(1, 3, 1, 0);
    cyc(1, 0, 2, 0);
    cyc(1, 0, 4, 0);
    cyc(1, 0, 3, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 9, 0);
    chk("rect_overrun", 32'(bus.err_code), 32'd3);
    cyc(0, 0, 0, 1);
    chk("rect_count", 32'(bus.cmd_count), 32'd2);

    // CLEAR
    cyc(1, 1, 31, 0);
    cyc(0, 0, 0, 0);
    chk("clear_flag", 32'(bus.exec_clear), 32'd1);
    chk("clear_x1", 32'(bus.x1), 32'd7);
    cyc(0, 0, 0, 1);

    // LINE abandoned by timeout
    cyc(1, 2, 0, 0);
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("timeout_code", 32'(bus.err_code), 32'd2);

    // LINE interrupted by a PIXEL start
    cyc(1, 2, 2, 0);
    cyc(1, 1, 4, 0);
    chk("protocol_code", 32'(bus.err_code), 32'd1);
    cyc(1, 0, 6, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    // reset in the middle of a load
    cyc(1, 3, 5, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    rst = 1'b0;

    for (int i = 0; i < 900; i++) begin
      en_pct = (i / 150) % 3 == 0 ? 75 : ((i / 150) % 3 == 1 ? 30 : 8);
      e = ($urandom_range(0, 99) < en_pct);
      c = ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(1, 3));
      p = ($urandom_range(0, 9) == 0) ? PMASK : int'($urandom_range(0, PMASK));
      r = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 199) == 0);
      cyc(e, c, p, r);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
